mult_seq: RTL and testbench
===========================

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-003 Port rst: input, 1 bit, synchronous active-high reset, sampled on clk rising edge.
REQ-004 Port start: input, 1 bit, multiply-unsigned issue request from decode, level-sampled each edge.
REQ-005 Port opA: input, 32 bits, multiplicand, captured only when a start is accepted.
REQ-006 Port opB: input, 32 bits, multiplier, captured only when a start is accepted.
REQ-007 Port rdHiLo: input, 1 bit, a move-from-HI or move-from-LO instruction is in decode this cycle.
REQ-008 Port hi: output, 32 bits, HI register, upper product word.
REQ-009 Port lo: output, 32 bits, LO register, lower product word.
REQ-010 Port busy: output, 1 bit, multiply in progress (RUN state).
REQ-011 Port done: output, 1 bit, one-cycle pulse, hi/lo just updated.
REQ-012 Port stall: output, 1 bit, combinational pipeline-hold request to decode.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE, with one-hot or binary encoding at implementer's choice.
REQ-014 In IDLE or DONE with start=1, it SHALL accept on that edge: mcand<=opA, P[63:0]<={32'h0,opB}, cnt<=0, state<=RUN.
REQ-015 In IDLE with start=0, state SHALL remain IDLE; in DONE with start=0, state SHALL go to IDLE.
REQ-016 Each RUN edge: sum[32:0] = P[0] ? {1'b0,P[63:32]}+{1'b0,mcand} : {1'b0,P[63:32]}; P<={sum,P[31:1]}; cnt<=cnt+1.
REQ-017 cnt SHALL be 5 bits; the RUN edge with cnt==31 SHALL write {hi,lo}<=final P and move to DONE.
REQ-018 Exactly 32 RUN cycles SHALL occur for every operand pair, with no early termination on zero operands.
REQ-019 Latency: start accepted on edge E, then hi/lo hold the result and done=1 after edge E+32, with done low after E+33 unless restarted.
REQ-020 busy SHALL be 1 iff state==RUN; done SHALL be 1 iff state==DONE.
REQ-021 hi/lo SHALL change only on the RUN-to-DONE edge or on reset, and SHALL hold the previous result throughout RUN.
REQ-022 stall SHALL equal busy & (start | rdHiLo), so no read of stale HI/LO and no overlapping issue is possible.
REQ-023 start during RUN SHALL be ignored (not queued); opA/opB changes during RUN SHALL have no effect.
REQ-024 start and rdHiLo both high in DONE: stall=0, the read sees the new hi/lo, and start is accepted (back-to-back issue).
REQ-025 Product SHALL be unsigned 64-bit exact; the 33-bit sum carry SHALL never be lost.

Reset
REQ-026 rst=1 SHALL force state=IDLE, cnt=0, P=0, mcand=0, hi=0, lo=0, hence busy=0, done=0, stall=0.
REQ-027 rst SHALL take priority over start on the same edge.
REQ-028 rst asserted mid-RUN SHALL abort the multiply with no hi/lo update and no done pulse.

Verification
REQ-029 Reset, then start with opA=3, opB=5 -> busy for 32 cycles, then done pulse, hi=0x00000000, lo=0x0000000F.
REQ-030 opA=opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at E+32.
REQ-031 During RUN, start=1 with opA=7, opB=7 and rdHiLo=1 at cycle 10 -> stall=1 both cycles, result still from the first operands, no second run begins.
REQ-032 rst pulsed at RUN cycle 10 after a prior result 0x1_00000000 -> hi=lo=0 after reset, busy=0, no done.
REQ-033 Back-to-back: start held in the DONE cycle with opA=2, opB=0x80000000 -> new run begins with no IDLE cycle, hi=0x00000001, lo=0x00000000 after 32 more edges.
REQ-034 opA=0, opB=0x12345678 -> still 32 busy cycles, hi=lo=0.

Source files
------------

// File: rtl/mult_seq.sv
// Sequential 32x32 unsigned shift-add multiplier with HI/LO result registers.
// One product bit is retired per RUN cycle; decode is held off while busy.
module mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        rdHiLo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [W-1:0]       mcand_q;
    logic [2*W-1:0]     p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       hi_q;
    logic [W-1:0]       lo_q;

    logic [W:0]         sum_d;
    logic [2*W-1:0]     p_d;

    // Add-and-shift step; the 33rd sum bit becomes the new MSB of P.
    always_comb begin
        sum_d = {1'b0, p_q[2*W-1:W]};
        if (p_q[0]) begin
            sum_d = {1'b0, p_q[2*W-1:W]} + {1'b0, mcand_q};
        end
        p_d = {sum_d, p_q[W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q <= opA;
                        p_q     <= {W'(0), opB};
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W - 1)) begin
                        hi_q    <= p_d[2*W-1:W];
                        lo_q    <= p_d[W-1:0];
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign stall = busy & (start | rdHiLo);

endmodule

// File: tb/tb_mult_seq.sv
// Randomized and directed bench for mult_seq against a 64-bit arithmetic product model.
module tb_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        rdHiLo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    mult_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .opA    (opA),
        .opB    (opB),
        .rdHiLo (rdHiLo),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue a multiply from IDLE/DONE and follow it to DONE; optionally poke start/rdHiLo mid-run.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int inject_at);
        int          cycles;
        bit          held;
        logic [63:0] prod;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        opA    = $urandom;
        opB    = $urandom;
        cycles = 0;
        held   = 1'b1;
        while (busy === 1'b1 && cycles < 40) begin
            held = held && (hi === exp_hi) && (lo === exp_lo) && (done === 1'b0);
            if (inject_at >= 0 && (cycles == inject_at || cycles == inject_at + 1)) begin
                start  = 1'b1;
                rdHiLo = 1'b1;
                opA    = 32'd7;
                opB    = 32'd7;
                #1;
                check("stall_in_run", 64'(stall), 64'd1);
            end else begin
                start  = 1'b0;
                rdHiLo = 1'b0;
            end
            tick();
            cycles++;
        end
        start  = 1'b0;
        rdHiLo = 1'b0;
        prod   = 64'(a) * 64'(b);
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        check("busy_cycles", 64'(cycles), 64'd32);
        check("hilo_held_in_run", 64'(held), 64'd1);
        check("done_pulse", 64'(done), 64'd1);
        check("hi", 64'(hi), 64'(exp_hi));
        check("lo", 64'(lo), 64'(exp_lo));
    endtask

    task automatic settle_idle();
        tick();
        check("done_low", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
        check("hilo_hold", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        rdHiLo = 1'b1;
        opA    = 32'hDEAD_BEEF;
        opB    = 32'h1234_5678;
        tick();
        tick();
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        rst    = 1'b0;
        start  = 1'b0;
        rdHiLo = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        run_op(32'd3, 32'd5, -1);
        settle_idle();

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        settle_idle();

        // Start and HI/LO read while running are stalled and do not requeue.
        run_op(32'h0001_2345, 32'h00AB_CDEF, 10);
        settle_idle();

        run_op(32'd0, 32'h1234_5678, -1);
        settle_idle();

        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, -1);
            settle_idle();
        end

        // Back-to-back issue from DONE while HI/LO is being read.
        run_op(32'h0001_0000, 32'h0001_0000, -1);
        start  = 1'b1;
        rdHiLo = 1'b1;
        opA    = 32'd2;
        opB    = 32'h8000_0000;
        #1;
        check("done_stall", 64'(stall), 64'd0);
        check("done_read", {hi, lo}, 64'h1_0000_0000);
        run_op(32'd2, 32'h8000_0000, -1);
        settle_idle();

        // Reset mid-run aborts without a result or done pulse.
        run_op(32'h0001_0000, 32'h0001_0000, -1);
        settle_idle();
        opA   = $urandom;
        opB   = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        begin
            bit saw_done = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            end
            check("abort_quiet", 64'(saw_done), 64'd0);
        end

        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        tick();
        check("rst_prio_idle", 64'(busy), 64'd0);

        run_op($urandom, 32'hFFFF_FFFF, -1);
        settle_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
